// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard controller: per-register countdown scoreboard, HI/LO occupancy and redirect flush.
// HI/LO (mult/div) tracking is present only when HDU_MDU_TRACK_EN is defined.
module hazard_scoreboard_unit #(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_LAT     = 1,
    parameter int MDU_LAT      = 4,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  IssueValid,
    input  logic [REG_ADDR_W-1:0] RS,
    input  logic [REG_ADDR_W-1:0] RT,
    input  logic                  RsUsed,
    input  logic                  RtUsed,
    input  logic [REG_ADDR_W-1:0] DestReg,
    input  logic                  DestWrite,
    input  logic                  IsLoad,
    input  logic                  IsMDU,
    input  logic                  UsesHiLo,
    input  logic                  Branch,
    input  logic                  Jump,
    output logic                  Stall,
    output logic                  PCWrite,
    output logic                  ControllerControl,
    output logic                  FlushControl,
    output logic                  HiLoControl,
    output logic                  MduBusy
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam int MAX_LAT  = (LOAD_LAT > MDU_LAT) ? LOAD_LAT : MDU_LAT;
    localparam int CNT_W    = $clog2(MAX_LAT + 1);
    localparam int FL_W     = $clog2(FLUSH_CYCLES + 1);

    logic [CNT_W-1:0] r_pend_cnt [NUM_REGS];
    logic [FL_W-1:0]  r_flush_cnt;

    logic w_redirect;
    logic w_flush;
    logic w_rs_hit;
    logic w_rt_hit;
    logic w_mdu_hit;
    logic w_mdu_active;
    logic w_hazard;
    logic w_accept;

    assign w_redirect = Branch | Jump;
    assign w_flush    = w_redirect | (r_flush_cnt != '0);
    // r0 is hard-wired zero, so it can never carry a pending write
    assign w_rs_hit   = RsUsed & (RS != '0) & (r_pend_cnt[RS] != '0);
    assign w_rt_hit   = RtUsed & (RT != '0) & (r_pend_cnt[RT] != '0);
    assign w_hazard   = IssueValid & (w_rs_hit | w_rt_hit | w_mdu_hit);
    assign w_accept   = IssueValid & ~w_hazard & ~w_flush;

`ifdef HDU_MDU_TRACK_EN
    logic [CNT_W-1:0] r_mdu_cnt;

    assign w_mdu_active = (r_mdu_cnt != '0);
    assign w_mdu_hit    = (UsesHiLo | IsMDU) & w_mdu_active;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_mdu_cnt <= '0;
        end else if (w_accept & IsMDU) begin
            r_mdu_cnt <= CNT_W'(MDU_LAT);
        end else if (w_mdu_active) begin
            r_mdu_cnt <= r_mdu_cnt - 1'b1;
        end
    end
`else
    logic w_unused_hilo;

    assign w_unused_hilo = UsesHiLo | IsMDU;
    assign w_mdu_active  = 1'b0;
    assign w_mdu_hit     = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_pend_cnt[r] <= '0;
            end
        end else begin
            r_pend_cnt[0] <= '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                // ALU results are forwarded, so a non-load write clears the entry
                if (w_accept & DestWrite & (DestReg == REG_ADDR_W'(r))) begin
                    r_pend_cnt[r] <= IsLoad ? CNT_W'(LOAD_LAT) : '0;
                end else if (r_pend_cnt[r] != '0) begin
                    r_pend_cnt[r] <= r_pend_cnt[r] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_flush_cnt <= '0;
        end else if (w_redirect) begin
            r_flush_cnt <= FL_W'(FLUSH_CYCLES - 1);
        end else if (r_flush_cnt != '0) begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
        end
    end

    always_comb begin
        Stall             = 1'b0;
        PCWrite           = 1'b1;
        ControllerControl = 1'b0;
        FlushControl      = 1'b0;
        HiLoControl       = 1'b0;
        MduBusy           = w_mdu_active & ~Reset;
        if (!Reset) begin
            if (w_flush) begin
                FlushControl      = 1'b1;
                ControllerControl = 1'b1;
                HiLoControl       = 1'b1;
            end else if (w_hazard) begin
                Stall             = 1'b1;
                PCWrite           = 1'b0;
                ControllerControl = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit with a cycle-time availability model checked every cycle.
module tb_hazard_scoreboard_unit;
    localparam int LOAD_LAT     = 1;
    localparam int MDU_LAT      = 4;
    localparam int FLUSH_CYCLES = 2;
`ifdef HDU_MDU_TRACK_EN
    localparam bit MEN = 1'b1;
`else
    localparam bit MEN = 1'b0;
`endif

    localparam logic [5:0] IDLE  = 6'b010000;
    localparam logic [5:0] STALL = 6'b101000;
    localparam logic [5:0] FLUSH = 6'b011110;
    localparam logic [5:0] MSTL  = MEN ? 6'b101001 : IDLE;
    localparam logic [5:0] MBSY  = MEN ? 6'b010001 : IDLE;

    typedef struct packed {
        logic       iv;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ru;
        logic       rtu;
        logic [4:0] dst;
        logic       dw;
        logic       ld;
        logic       mdu;
        logic       hl;
    } ins_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       IssueValid = 1'b0;
    logic [4:0] RS = '0, RT = '0, DestReg = '0;
    logic       RsUsed = 1'b0, RtUsed = 1'b0, DestWrite = 1'b0;
    logic       IsLoad = 1'b0, IsMDU = 1'b0, UsesHiLo = 1'b0;
    logic       Branch = 1'b0, Jump = 1'b0;
    logic       Stall, PCWrite, ControllerControl, FlushControl, HiLoControl, MduBusy;
    logic [5:0] w_out;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // model: first cycle at which each resource may be consumed again
    int m_avail [32];
    int m_mdu_avail = 0;
    int m_flush_last = -100;

    hazard_scoreboard_unit #(
        .REG_ADDR_W  (5),
        .LOAD_LAT    (LOAD_LAT),
        .MDU_LAT     (MDU_LAT),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .IssueValid       (IssueValid),
        .RS               (RS),
        .RT               (RT),
        .RsUsed           (RsUsed),
        .RtUsed           (RtUsed),
        .DestReg          (DestReg),
        .DestWrite        (DestWrite),
        .IsLoad           (IsLoad),
        .IsMDU            (IsMDU),
        .UsesHiLo         (UsesHiLo),
        .Branch           (Branch),
        .Jump             (Jump),
        .Stall            (Stall),
        .PCWrite          (PCWrite),
        .ControllerControl(ControllerControl),
        .FlushControl     (FlushControl),
        .HiLoControl      (HiLoControl),
        .MduBusy          (MduBusy)
    );

    assign w_out = {Stall, PCWrite, ControllerControl, FlushControl, HiLoControl, MduBusy};

    always #5 Clk = ~Clk;

    initial begin
        for (int i = 0; i < 32; i++) m_avail[i] = 0;
    end

    function automatic logic m_mdu_busy();
        return MEN && (cyc < m_mdu_avail);
    endfunction

    function automatic logic m_flushing();
        return Branch || Jump || (cyc <= m_flush_last);
    endfunction

    function automatic logic m_hazard();
        logic rs_b, rt_b;
        rs_b = RsUsed && (RS != 0) && (cyc < m_avail[RS]);
        rt_b = RtUsed && (RT != 0) && (cyc < m_avail[RT]);
        return IssueValid && (rs_b || rt_b || ((UsesHiLo || IsMDU) && m_mdu_busy()));
    endfunction

    function automatic logic [5:0] m_expect();
        if (Reset) return IDLE;
        if (m_flushing()) return {5'b01111, m_mdu_busy()};
        if (m_hazard()) return {5'b10100, m_mdu_busy()};
        return {5'b01000, m_mdu_busy()};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) m_avail[i] <= 0;
            m_mdu_avail  <= 0;
            m_flush_last <= -100;
        end else begin
            if (IssueValid && !m_hazard() && !m_flushing()) begin
                if (DestWrite && DestReg != 0)
                    m_avail[DestReg] <= IsLoad ? cyc + 1 + LOAD_LAT : 0;
                if (IsMDU)
                    m_mdu_avail <= cyc + 1 + MDU_LAT;
            end
            if (Branch || Jump) m_flush_last <= cyc + FLUSH_CYCLES - 1;
        end
        cyc <= cyc + 1;
    end

    always @(negedge Clk) check("model", w_out, m_expect());

    function automatic ins_t mk(logic [4:0] rs, logic [4:0] rt, logic ru, logic rtu,
                                logic [4:0] dst, logic dw, logic ld, logic mdu, logic hl);
        ins_t i;
        i.iv = 1'b1; i.rs = rs; i.rt = rt; i.ru = ru; i.rtu = rtu;
        i.dst = dst; i.dw = dw; i.ld = ld; i.mdu = mdu; i.hl = hl;
        return i;
    endfunction

    function automatic ins_t f_nop();
        ins_t i;
        i = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        i.iv = 1'b0;
        return i;
    endfunction

    function automatic ins_t f_lw(logic [4:0] dst, logic [4:0] base);
        return mk(base, 0, 1, 0, dst, 1, 1, 0, 0);
    endfunction

    function automatic ins_t f_add(logic [4:0] rs, logic [4:0] rt, logic [4:0] dst);
        return mk(rs, rt, 1, 1, dst, 1, 0, 0, 0);
    endfunction

    function automatic ins_t f_addi(logic [4:0] rs, logic [4:0] dst);
        return mk(rs, dst, 1, 0, dst, 1, 0, 0, 0);
    endfunction

    function automatic ins_t f_mult(logic [4:0] rs, logic [4:0] rt);
        return mk(rs, rt, 1, 1, 0, 0, 0, 1, 0);
    endfunction

    function automatic ins_t f_mfhi(logic [4:0] dst);
        return mk(0, 0, 0, 0, dst, 1, 0, 0, 1);
    endfunction

    task automatic step(input ins_t i, input logic br, input logic jp, input logic rst);
        @(posedge Clk);
        #1;
        IssueValid = i.iv; RS = i.rs; RT = i.rt; RsUsed = i.ru; RtUsed = i.rtu;
        DestReg = i.dst; DestWrite = i.dw; IsLoad = i.ld; IsMDU = i.mdu; UsesHiLo = i.hl;
        Branch = br; Jump = jp; Reset = rst;
    endtask

    task automatic step_chk(input ins_t i, input logic br, input logic jp, input logic rst,
                            input logic [5:0] exp, input string name);
        step(i, br, jp, rst);
        @(negedge Clk);
        check(name, w_out, exp);
    endtask

    initial begin
        ins_t inv;

        step_chk(f_add(8, 9, 10), 1, 0, 1, IDLE, "reset_force");
        step(f_nop(), 0, 0, 1);

        step_chk(f_lw(8, 0), 0, 0, 0, IDLE, "lw8");
        step_chk(f_add(8, 9, 10), 0, 0, 0, STALL, "loaduse_stall");
        step_chk(f_add(8, 9, 10), 0, 0, 0, IDLE, "loaduse_accept");

        step_chk(f_lw(0, 0), 0, 0, 0, IDLE, "lw_r0");
        step_chk(f_add(0, 0, 11), 0, 0, 0, IDLE, "r0_use");

        step_chk(f_lw(8, 0), 0, 0, 0, IDLE, "lw8_again");
        step_chk(f_add(9, 10, 11), 0, 0, 0, IDLE, "indep_use");
        step_chk(f_add(1, 2, 8), 0, 0, 0, IDLE, "alu_wr8");
        step_chk(f_add(8, 8, 12), 0, 0, 0, IDLE, "alu_fwd");

        step_chk(f_lw(12, 0), 0, 0, 0, IDLE, "lw12");
        step_chk(f_addi(3, 12), 0, 0, 0, IDLE, "rt_unused");

        step_chk(f_lw(13, 0), 0, 0, 0, IDLE, "lw13");
        inv = f_add(13, 0, 0);
        inv.iv = 1'b0;
        step_chk(inv, 0, 0, 0, IDLE, "invalid_no_stall");
        step_chk(f_add(13, 0, 0), 0, 0, 0, IDLE, "after_invalid");

        step_chk(f_lw(14, 0), 0, 0, 0, IDLE, "lw14");
        step_chk(f_add(1, 14, 2), 0, 0, 0, STALL, "rt_stall");
        step(f_add(1, 14, 2), 0, 0, 0);

        step_chk(f_mult(1, 2), 0, 0, 0, IDLE, "mult");
        step_chk(f_mfhi(15), 0, 0, 0, MSTL, "mfhi_t1");
        step(f_mfhi(15), 0, 0, 0);
        step(f_mfhi(15), 0, 0, 0);
        step_chk(f_mfhi(15), 0, 0, 0, MSTL, "mfhi_t4");
        step_chk(f_mfhi(15), 0, 0, 0, IDLE, "mfhi_t5");

        step_chk(f_mult(3, 4), 0, 0, 0, IDLE, "mult2");
        step_chk(f_mult(5, 6), 0, 0, 0, MSTL, "mult_mult");
        step_chk(f_add(1, 2, 3), 0, 0, 0, MBSY, "alu_during_mdu");
        step(f_nop(), 0, 0, 0);
        step(f_nop(), 0, 0, 0);
        step(f_nop(), 0, 0, 0);

        step_chk(f_lw(8, 0), 0, 0, 0, IDLE, "lw8_flush");
        step_chk(f_lw(14, 8), 1, 0, 0, FLUSH, "flush_over_stall");
        step_chk(f_lw(14, 8), 0, 0, 0, FLUSH, "flush_hold");
        step_chk(f_add(14, 0, 0), 0, 0, 0, IDLE, "flush_no_update");

        step_chk(f_nop(), 0, 1, 0, FLUSH, "jump1");
        step_chk(f_nop(), 0, 1, 0, FLUSH, "jump2");
        step_chk(f_nop(), 0, 0, 0, FLUSH, "flush_restart");
        step_chk(f_nop(), 0, 0, 0, IDLE, "flush_end");

        step_chk(f_mult(1, 2), 0, 0, 0, IDLE, "mult_rst");
        step(f_mfhi(16), 0, 0, 0);
        step_chk(f_mfhi(16), 0, 0, 1, IDLE, "reset_midop");
        step_chk(f_mfhi(16), 0, 0, 0, IDLE, "post_reset_accept");
        step(f_lw(8, 0), 0, 0, 0);
        step_chk(f_add(8, 0, 0), 0, 0, 1, IDLE, "reset_load");
        step_chk(f_add(8, 0, 0), 0, 0, 0, IDLE, "post_reset_load");

        for (int r = 1; r < 32; r++) begin
            ins_t use_i;
            use_i = (r % 2 == 1) ? f_add(5'(r), 0, 0) : f_add(0, 5'(r), 0);
            step_chk(f_lw(5'(r), 0), 0, 0, 0, IDLE, "walk_lw");
            step_chk(use_i, 0, 0, 0, STALL, "walk_stall");
            step_chk(use_i, 0, 0, 0, IDLE, "walk_accept");
        end

        step(f_nop(), 0, 0, 0);
        @(posedge Clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Parametrised hazard controller for the ID stage of the pipelined MIPS core. It tracks pending register writes with per-register countdown scoreboards and multi-cycle HI/LO (mult/div) occupancy. From that state it generates stall, PC-hold, bubble-insert and multi-cycle flush controls. It sits beside the IF/ID and ID/EX pipeline registers and drives their write-enable and clear inputs.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width; NUM_REGS = 2**REG_ADDR_W
- LOAD_LAT, 1, cycles a load destination is unavailable to a following instruction (≥1)
- MDU_LAT, 4, cycles HI/LO is busy after a mult/div issues (≥1)
- FLUSH_CYCLES, 1, cycles FlushControl stays high per taken redirect (≥1)
- Derived localparam CNT_W = $clog2(max(LOAD_LAT, MDU_LAT)+1)

Ports (one clock; reset is synchronous and active-high):
- Clk  in  1  clock; all state on rising edge
- Reset  in  1  synchronous, active-high; clears all state
- IssueValid  in  1  valid instruction in ID
- RS, RT  in  REG_ADDR_W  source registers of ID instruction
- RsUsed, RtUsed  in  1  source actually read
- DestReg  in  REG_ADDR_W  destination of ID instruction
- DestWrite  in  1  instruction writes DestReg
- IsLoad  in  1  instruction is a load
- IsMDU  in  1  instruction is mult/div (writes HI/LO)
- UsesHiLo  in  1  instruction reads HI/LO (mfhi/mflo)
- Branch, Jump  in  1  taken redirect resolved this cycle
- Stall  out  1  hold IF/ID
- PCWrite  out  1  1 = PC updates, 0 = PC held
- ControllerControl  out  1  zero control fields into ID/EX (bubble)
- FlushControl  out  1  clear IF/ID
- HiLoControl  out  1  block HI/LO write
- MduBusy  out  1  HI/LO occupancy counter nonzero

## Operation
- State: pend_cnt[r] (CNT_W bits) for r = 1..NUM_REGS-1; mdu_cnt (CNT_W); flush_cnt ($clog2(FLUSH_CYCLES+1)). Register 0 is never tracked; hazards on r0 never occur.
- redirect = Branch | Jump; Flush = redirect | (flush_cnt != 0).
- Hazard = IssueValid & ((RsUsed & pend_cnt[RS]!=0) | (RtUsed & pend_cnt[RT]!=0) | ((UsesHiLo|IsMDU) & mdu_cnt!=0)), with the mdu term present only under the configuration macro.
- Priority: Flush over stall. If Flush: FlushControl=1, ControllerControl=1, HiLoControl=1, Stall=0, PCWrite=1. Else if Hazard: Stall=1, PCWrite=0, ControllerControl=1. Else all idle.
- Accept = IssueValid & ~Hazard & ~Flush. On accept with DestWrite & DestReg≠0: pend_cnt[DestReg] ← IsLoad ? LOAD_LAT : 0. ALU results are forwarded and need no hazard. On accept with IsMDU: mdu_cnt ← MDU_LAT.
- Every cycle, each nonzero counter not being reloaded decrements by 1. When a reload and a decrement hit the same counter in the same cycle, the reload wins.
- redirect loads flush_cnt ← FLUSH_CYCLES-1; otherwise a nonzero flush_cnt decrements. redirect during an active flush restarts the count.
- Counters saturate at 0; no wrap.

## Timing
- Outputs are combinational from registered state plus current inputs. Zero-cycle latency from inputs.
- While Reset=1, outputs are forced to Stall=0, PCWrite=1, ControllerControl=0, FlushControl=0, HiLoControl=0, MduBusy=0. The following edge clears all counters.
- Reset mid-operation discards all pending hazards. The first cycle after deassertion is hazard-free.
- Load accepted in cycle t (LOAD_LAT=1): a dependent instruction in ID at t+1 stalls one cycle and is accepted at t+2.
- Mult accepted in cycle t (MDU_LAT=4): MduBusy=1 during t+1..t+4. mfhi is stalled in those cycles and accepted at t+5.
- redirect at cycle t: FlushControl high for cycles t..t+FLUSH_CYCLES-1.

## Configuration
- HDU_MDU_TRACK_EN defined: mdu_cnt, HI/LO hazard term and MduBusy are implemented as above.
- HDU_MDU_TRACK_EN undefined: mdu_cnt is removed, MduBusy is tied 0, and UsesHiLo/IsMDU never cause stalls. HiLoControl still follows Flush.

## Test plan
- Load-use: lw $8 at t, then add using RS=8 at t+1 → Stall=1, PCWrite=0, ControllerControl=1 at t+1. Accepted at t+2.
- r0 writer: lw $0, then use RS=0 → no stall.
- Independent use: lw $8, then add on $9,$10 → no stall. ALU write to $8 followed by use of $8 → no stall.
- MDU (macro on): mult at t, mfhi waiting from t+1 → stalled t+1..t+4, accepted t+5, MduBusy falls at t+5. With macro off → no stall.
- Flush priority, FLUSH_CYCLES=2: Branch=1 at t while a load-use hazard is present → FlushControl=1 at t and t+1, Stall=0, no scoreboard update from the ID instruction.
- Reset mid-op: mult at t, Reset at t+2 → MduBusy=0 from t+2. mfhi at t+3 is accepted.
